rx_frame_sequencer: RTL and testbench

Controls the serial receive datapath. It detects a start bit on an oversampled serial line and times the mid-bit samples with an oversample counter and a bit counter. It shifts DATA_W bits into a shift register LSB-first, checks the stop bit, and hands the frame to the consumer through a one-entry holding register with a valid/ready handshake. It also flags framing errors and overruns, and sits between the line synchroniser and the receive FIFO/consumer.

---
 rtl/rx_frame_if.sv | 33 +++
 rtl/rx_frame_sequencer.sv | 159 +++++++++++++++
 tb/tb_rx_frame_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_if.sv
// ============================================================================
//  Module   : rx_frame_if
//  Brief    : Control, serial line and holding-register handshake bundle for
//             the serial receive sequencer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface rx_frame_if #(
    parameter int DATA_W = 8
);
    logic              enable;
    logic              serial_in;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              frame_err;
    logic              overrun;
    logic              clr_err;
    logic              busy;

    modport master (
        input  enable, serial_in, rx_ready, clr_err,
        output rx_data, rx_valid, frame_err, overrun, busy
    );

    modport slave (
        output enable, serial_in, rx_ready, clr_err,
        input  rx_data, rx_valid, frame_err, overrun, busy
    );
endinterface

`default_nettype wire

// File: rtl/rx_frame_sequencer.sv
// ============================================================================
//  Module   : rx_frame_sequencer
//  Brief    : Oversampled serial frame receiver with one-entry holding
//             register, framing-error pulse and sticky overrun flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rx_frame_sequencer #(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 4
) (
    input  logic          clock,
    input  logic          reset,
    rx_frame_if.master    bus
);

    localparam int OS_W = $clog2(OVERSAMPLE) + 1;
    localparam int BC_W = $clog2(DATA_W) + 1;

    localparam logic [OS_W-1:0] c_OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] c_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BC_W-1:0] c_BIT_LAST  = BC_W'(DATA_W - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_WAIT_HIGH = 3'd4;

    logic [2:0]        r_state;
    logic [OS_W-1:0]   r_os_cnt;
    logic [BC_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_frame_err;
    logic              r_overrun;

    logic [DATA_W-1:0] w_shift_next;
    logic              w_os_last;
    logic              w_stop_good;
    logic              w_load;
    logic              w_drop;

    // LSB-first frame: each new bit enters at the MSB and moves down
    generate
        if (DATA_W == 1) begin : g_shift_one
            assign w_shift_next = bus.serial_in;
        end else begin : g_shift_multi
            assign w_shift_next = {bus.serial_in, r_shift[DATA_W-1:1]};
        end
    endgenerate

    assign w_os_last   = (r_os_cnt == c_OS_LAST);
    assign w_stop_good = (r_state == c_STOP) && bus.enable && w_os_last && bus.serial_in;
    assign w_load      = w_stop_good && (!r_rx_valid || bus.rx_ready);
    assign w_drop      = w_stop_good && r_rx_valid && !bus.rx_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_os_cnt    <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_os_cnt <= '0;
                    if (bus.enable && !bus.serial_in) begin
                        r_state <= c_START;
                    end
                end
                c_START: begin
                    if (!bus.enable) begin
                        r_state  <= c_IDLE;
                        r_os_cnt <= '0;
                    end else if (r_os_cnt == c_HALF_LAST) begin
                        r_os_cnt  <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= bus.serial_in ? c_IDLE : c_DATA;
                    end else begin
                        r_os_cnt <= r_os_cnt + OS_W'(1);
                    end
                end
                c_DATA: begin
                    if (!bus.enable) begin
                        r_state  <= c_IDLE;
                        r_os_cnt <= '0;
                    end else if (w_os_last) begin
                        r_os_cnt  <= '0;
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= r_bit_cnt + BC_W'(1);
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_state <= c_STOP;
                        end
                    end else begin
                        r_os_cnt <= r_os_cnt + OS_W'(1);
                    end
                end
                c_STOP: begin
                    if (!bus.enable) begin
                        r_state  <= c_IDLE;
                        r_os_cnt <= '0;
                    end else if (w_os_last) begin
                        r_os_cnt    <= '0;
                        r_state     <= bus.serial_in ? c_IDLE : c_WAIT_HIGH;
                        r_frame_err <= !bus.serial_in;
                    end else begin
                        r_os_cnt <= r_os_cnt + OS_W'(1);
                    end
                end
                // A held-low line (break) must rise before a new start is accepted
                c_WAIT_HIGH: begin
                    if (bus.serial_in) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state  <= c_IDLE;
                    r_os_cnt <= '0;
                end
            endcase
        end
    end

    // Holding register runs independently of the receive state and enable
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_load) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.clr_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = r_rx_data;
    assign bus.rx_valid  = r_rx_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;
    assign bus.busy      = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rx_frame_sequencer.sv
// ============================================================================
//  Module   : tb_rx_frame_sequencer
//  Brief    : Self-checking bench: timeline-based reference model compared
//             every cycle, plus directed literal checks and random traffic.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rx_frame_sequencer;

    localparam int DW   = 8;
    localparam int OS   = 4;
    localparam int HALF = OS / 2;

    logic clock;
    logic reset;

    rx_frame_if #(.DATA_W(DW)) bus ();

    rx_frame_sequencer #(
        .DATA_W     (DW),
        .OVERSAMPLE (OS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    bit rand_on = 1'b0;

    // Reference model: mode 0 idle, 1 receiving, 2 waiting for line high.
    // m_k is the number of edges elapsed since the start-detect edge.
    int           m_mode;
    int           m_k;
    logic [DW-1:0] m_bits;
    logic [DW-1:0] m_data;
    logic         m_valid;
    logic         m_ferr;
    logic         m_ovr;

    always @(posedge clock) begin : model
        bit load;
        bit drop;
        int idx;
        load = 1'b0;
        drop = 1'b0;
        if (!reset) begin
            m_mode  <= 0;
            m_k     <= 0;
            m_bits  <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
            m_ferr  <= 1'b0;
            m_ovr   <= 1'b0;
        end else begin
            m_ferr <= 1'b0;
            case (m_mode)
                0: if (bus.enable && !bus.serial_in) begin
                    m_mode <= 1;
                    m_k    <= 1;
                end
                1: if (!bus.enable) begin
                    m_mode <= 0;
                end else begin
                    m_k <= m_k + 1;
                    if (m_k == HALF) begin
                        if (bus.serial_in) m_mode <= 0;
                    end else if (m_k > HALF && (m_k - HALF) % OS == 0) begin
                        idx = (m_k - HALF) / OS - 1;
                        if (idx < DW) begin
                            m_bits[idx] <= bus.serial_in;
                        end else if (bus.serial_in) begin
                            m_mode <= 0;
                            if (!m_valid || bus.rx_ready) load = 1'b1;
                            else drop = 1'b1;
                        end else begin
                            m_mode <= 2;
                            m_ferr <= 1'b1;
                        end
                    end
                end
                default: if (bus.serial_in) m_mode <= 0;
            endcase
            if (load) begin
                m_data  <= m_bits;
                m_valid <= 1'b1;
            end else if (m_valid && bus.rx_ready) begin
                m_valid <= 1'b0;
            end
            if (drop) m_ovr <= 1'b1;
            else if (bus.clr_err) m_ovr <= 1'b0;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            n_tests = n_tests + 1;
            if (bus.rx_data !== m_data || bus.rx_valid !== m_valid ||
                bus.frame_err !== m_ferr || bus.overrun !== m_ovr ||
                bus.busy !== (m_mode != 0)) begin
                n_fail = n_fail + 1;
                $display("FAIL cycle_cmp @%0t: dut data=%h valid=%b ferr=%b ovr=%b busy=%b, model data=%h valid=%b ferr=%b ovr=%b busy=%b",
                         $time, bus.rx_data, bus.rx_valid, bus.frame_err, bus.overrun, bus.busy,
                         m_data, m_valid, m_ferr, m_ovr, (m_mode != 0));
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rand_ctl();
        if (rand_on) begin
            bus.rx_ready = ($urandom % 3) != 0;
            bus.clr_err  = ($urandom % 20) == 0;
            bus.enable   = ($urandom % 80) != 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.serial_in = 1'b1;
            rand_ctl();
            @(negedge clock);
        end
    endtask

    // Drives the first ncyc line cycles of a frame; cycle 0 is sampled at edge t
    task automatic drive_frame(input logic [DW-1:0] d, input logic stop, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            if (c < OS) bus.serial_in = 1'b0;
            else if (c < (DW + 1) * OS) bus.serial_in = d[c / OS - 1];
            else bus.serial_in = stop;
            rand_ctl();
            @(negedge clock);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        reset         = 1'b0;
        bus.enable    = 1'b1;
        bus.serial_in = 1'b1;
        bus.rx_ready  = 1'b1;
        bus.clr_err   = 1'b0;
        @(negedge clock);
        chk_en = 1'b1;
        repeat (2) @(negedge clock);
        check("reset_valid", bus.rx_valid, 0);
        check("reset_data", bus.rx_data, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_ovr", bus.overrun, 0);
        reset = 1'b1;
        idle(3);

        // Good frame 0xA5: data visible after the stop-sample edge
        drive_frame(8'hA5, 1'b1, 39);
        check("a5_data", bus.rx_data, 8'hA5);
        check("a5_valid", bus.rx_valid, 1);
        check("a5_busy_done", bus.busy, 0);
        idle(1);
        check("a5_valid_one_cycle", bus.rx_valid, 0);
        idle(3);

        // False start
        bus.serial_in = 1'b0;
        @(negedge clock);
        bus.serial_in = 1'b1;
        check("fs_busy_t0", bus.busy, 1);
        @(negedge clock);
        check("fs_busy_t1", bus.busy, 1);
        @(negedge clock);
        check("fs_busy_t2", bus.busy, 0);
        check("fs_valid", bus.rx_valid, 0);
        check("fs_ovr", bus.overrun, 0);
        idle(3);

        // Framing error with break, then a clean frame
        drive_frame(8'h5A, 1'b0, 39);
        check("fe_pulse", bus.frame_err, 1);
        check("fe_valid", bus.rx_valid, 0);
        for (int i = 0; i < 10; i++) begin
            bus.serial_in = 1'b0;
            @(negedge clock);
        end
        check("fe_wait_busy", bus.busy, 1);
        check("fe_not_sticky", bus.frame_err, 0);
        idle(1);
        check("fe_idle_after_rise", bus.busy, 0);
        idle(2);
        drive_frame(8'h11, 1'b1, 39);
        check("after_fe_data", bus.rx_data, 8'h11);
        check("after_fe_valid", bus.rx_valid, 1);
        idle(4);

        // Overrun
        bus.rx_ready = 1'b0;
        drive_frame(8'h3C, 1'b1, 39);
        idle(3);
        check("ov_first_data", bus.rx_data, 8'h3C);
        check("ov_first_ovr", bus.overrun, 0);
        drive_frame(8'hC3, 1'b1, 39);
        check("ov_flag", bus.overrun, 1);
        check("ov_data_kept", bus.rx_data, 8'h3C);
        bus.clr_err = 1'b1;
        @(negedge clock);
        bus.clr_err = 1'b0;
        check("ov_cleared", bus.overrun, 0);
        bus.rx_ready = 1'b1;
        @(negedge clock);
        check("ov_accepted", bus.rx_valid, 0);
        check("ov_accept_data", bus.rx_data, 8'h3C);
        idle(3);

        // Accept and reload on the same edge
        bus.rx_ready = 1'b0;
        drive_frame(8'h01, 1'b1, 39);
        idle(3);
        drive_frame(8'h02, 1'b1, 38);
        bus.rx_ready  = 1'b1;
        bus.serial_in = 1'b1;
        @(negedge clock);
        bus.rx_ready = 1'b0;
        check("same_edge_valid", bus.rx_valid, 1);
        check("same_edge_data", bus.rx_data, 8'h02);
        check("same_edge_ovr", bus.overrun, 0);
        idle(2);
        bus.rx_ready = 1'b1;
        idle(3);

        // Reset mid-frame
        drive_frame(8'h7E, 1'b1, 20);
        reset = 1'b0;
        bus.serial_in = 1'b1;
        @(negedge clock);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_valid", bus.rx_valid, 0);
        check("rst_mid_data", bus.rx_data, 0);
        reset = 1'b1;
        idle(3);
        drive_frame(8'h7E, 1'b1, 39);
        check("post_rst_data", bus.rx_data, 8'h7E);
        check("post_rst_valid", bus.rx_valid, 1);
        idle(3);

        // Enable dropped mid-frame
        bus.rx_ready = 1'b0;
        drive_frame(8'h7E, 1'b1, 20);
        bus.enable    = 1'b0;
        bus.serial_in = 1'b1;
        @(negedge clock);
        check("en_abort_busy", bus.busy, 0);
        bus.enable = 1'b1;
        idle(30);
        check("en_abort_no_valid", bus.rx_valid, 0);
        bus.rx_ready = 1'b1;
        idle(3);

        // Random traffic checked by the model every cycle
        rand_on = 1'b1;
        for (int f = 0; f < 60; f++) begin
            if ($urandom % 8 == 0) begin
                bus.serial_in = 1'b0;
                rand_ctl();
                @(negedge clock);
                idle(3);
            end else begin
                rd = DW'($urandom);
                drive_frame(rd, ($urandom % 5) != 0, 40);
                idle(1 + int'($urandom % 5));
            end
        end
        rand_on      = 1'b0;
        bus.enable   = 1'b1;
        bus.rx_ready = 1'b1;
        bus.clr_err  = 1'b0;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
